// File: rtl/adder_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated adder.
// Default sizes, ID width helper and FSM state encoding.
package adder_rr_arbiter_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int NUM_REQ_DEF = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Width of a requester index; never below one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_adder.sv
// 32-bit ripple-carry adder used as the shared datapath.
// Ports: a_i, b_i, cin_i in; sum_o, cout_o out.
module adder_32b (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  always_comb begin : ripple
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < 32; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// NUM_REQ requesters share one adder through a round-robin grant.
// Ports: clk, rst, req_* (valid/ready/a/b/cin), rsp_* (valid/ready/id/sum/cout).
module adder_rr_arbiter
  import adder_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [id_w(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout
);

  localparam int IW = id_w(NUM_REQ);

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      ptr_d;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      id_q;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   sum_w;
  logic [WIDTH-1:0]   sum_q;
  logic               cin_sel;
  logic               cout_w;
  logic               cout_q;
  logic               valid_q;
  logic               found;
  logic               slot_free;
  logic               grant;
  logic [NUM_REQ-1:0] onehot;

  // Pass 0 scans indices at/above the pointer, pass 1 wraps to 0.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    onehot  = '0;
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] &&
            (p == 1 || IW'(i) >= ptr_q)) begin
          found     = 1'b1;
          gnt_idx   = IW'(i);
          onehot[i] = 1'b1;
          a_sel     = req_a[i*WIDTH +: WIDTH];
          b_sel     = req_b[i*WIDTH +: WIDTH];
          cin_sel   = req_cin[i];
        end
      end
    end
  end

  always_comb begin
    slot_free = !rst && (state_q == EMPTY || rsp_ready);
    grant     = slot_free && found;
    req_ready = grant ? onehot : '0;
    ptr_d     = (gnt_idx == IW'(NUM_REQ - 1)) ?
                '0 : gnt_idx + IW'(1);
  end

  adder_32b u_add (
    .a_i    (a_sel),
    .b_i    (b_sel),
    .cin_i  (cin_sel),
    .sum_o  (sum_w),
    .cout_o (cout_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (grant) ptr_q <= ptr_d;
      unique case (state_q)
        EMPTY: begin
          if (grant) begin
            state_q <= FULL;
            valid_q <= 1'b1;
            id_q    <= gnt_idx;
            sum_q   <= sum_w;
            cout_q  <= cout_w;
          end
        end
        FULL: begin
          if (rsp_ready) begin
            if (grant) begin
              id_q   <= gnt_idx;
              sum_q  <= sum_w;
              cout_q <= cout_w;
            end else begin
              state_q <= EMPTY;
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

endmodule

// File: doc/adder_rr_arbiter.md
ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (2..8) sharing one 32-bit adder.
REQ-002 Parameter: WIDTH, 32, operand width; fixed to the shared adder width.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 Port: req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 Port: req_a  input  NUM_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 Port: req_b  input  NUM_REQ*WIDTH  operand B, same packing as req_a.
REQ-009 Port: req_cin  input  NUM_REQ  carry-in per requester.
REQ-010 Port: rsp_valid  output  1  result register holds a valid result.
REQ-011 Port: rsp_ready  input  1  consumer accepts result.
REQ-012 Port: rsp_id  output  clog2(NUM_REQ)  index of requester that owns the result.
REQ-013 Port: rsp_sum  output  WIDTH  registered sum.
REQ-014 Port: rsp_cout  output  1  registered carry-out.

Function
REQ-015 Transfer on a request port occurs when req_valid[i] and req_ready[i] are both high at a rising edge; response transfer when rsp_valid and rsp_ready are both high.
REQ-016 State machine, two states: EMPTY (result register free) and FULL (result held).
REQ-017 Slot free = (state==EMPTY) or (state==FULL and rsp_ready); req_ready is all-zero when slot not free.
REQ-018 When slot free and any req_valid high, grant exactly one requester: first valid index at or after rr_ptr, searching upward modulo NUM_REQ.
REQ-019 Granted operands drive the shared adder combinationally; sum, cout and grant index are registered on the transfer edge: latency 1 cycle from accept to rsp_valid.
REQ-020 Transitions: EMPTY+grant->FULL; FULL+rsp_ready+grant->FULL (back-to-back, new result replaces old); FULL+rsp_ready+no grant->EMPTY; FULL+!rsp_ready->FULL with rsp_* held stable.
REQ-021 rr_ptr updates only on a grant, to (granted index+1) mod NUM_REQ; wraps from NUM_REQ-1 to 0.
REQ-022 Sum is modulo 2^WIDTH; overflow reported only via rsp_cout; no saturation.
REQ-023 req_ready is combinational from req_valid, state, rsp_ready, rr_ptr; no requester starves: any held request is granted within NUM_REQ grants.
REQ-024 req_valid deasserted by a requester before acceptance is legal; no state change results.

Reset
REQ-025 On rst high, immediately: state=EMPTY, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0; req_ready=0 while rst high.
REQ-026 Reset mid-operation discards any held result; first grant after release starts search at index 0.

Structure
REQ-027 Shared package holds WIDTH default, NUM_REQ default, ID width function/constant, and state encoding (EMPTY=0, FULL=1).
REQ-028 Exactly one instance of the existing 32-bit ripple adder sub-module (adder_32b) is the shared datapath; the round-robin priority picker stays inline.

Verification
REQ-029 Single req: req_valid=0001, a=0xFFFFFFFF, b=1, cin=0 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=0, rsp_cout=1.
REQ-030 All four valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; one rsp per cycle.
REQ-031 Backpressure: rsp_ready=0 with result held, req_valid=0010 -> req_ready=0, rsp_* stable for 5 cycles; raise rsp_ready -> requester 1 granted same cycle, its result next cycle.
REQ-032 Wrap: rr_ptr=3, req_valid=1001 -> grant 3, then grant 0 next free slot.
REQ-033 Async reset asserted mid-cycle while FULL -> rsp_valid drops before next clock edge; after release req_valid=1111 -> first grant index 0.
REQ-034 Random stimulus, 10k ops: every rsp_sum/rsp_cout equals a+b+cin of the tagged requester's accepted operands; scoreboard per rsp_id.
